// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven level generator advancing on a divided tick,
// scaling the incoming 8-bit wave sample by (level+1)/256 with one cycle of latency.
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] sample_in,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  output logic [7:0] sample_out,
  output logic [7:0] level,
  output logic       active
);

  localparam int unsigned DATA_W = 8;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t            state, state_next;
  logic [15:0]       tick_cnt;
  logic              tick;
  logic              gate_q;
  logic              rise;
  logic [DATA_W-1:0] level_next;
  logic [DATA_W-1:0] sample_p1;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Subtract with a lower clamp; extra sign bits keep underflow visible.
  function automatic logic [DATA_W-1:0] floor_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] floor);
    logic signed [DATA_W+1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < $signed({2'b00, floor})) return floor;
    return d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s,
                                              input logic [DATA_W-1:0] lv);
    logic [2*DATA_W:0] p;
    p = (2*DATA_W+1)'(s) * (2*DATA_W+1)'({1'b0, lv} + 9'd1);
    return DATA_W'(p >> DATA_W);
  endfunction

  assign tick = (tick_cnt == TICK_LAST);
  assign rise = gate & ~gate_q;

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 16'd1;
  end

  always_comb begin
    state_next = state;
    level_next = level;
    if (rise) begin
      state_next = ATTACK;
    end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_next = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          level_next = (attack_rate == '0) ? {DATA_W{1'b1}} : sat_add(level, attack_rate);
          if (level_next == {DATA_W{1'b1}}) state_next = DECAY;
        end
        DECAY: begin
          level_next = (decay_rate == '0) ? sustain_level
                                          : floor_sub(level, decay_rate, sustain_level);
          if (level_next == sustain_level) state_next = SUSTAIN;
        end
        SUSTAIN: level_next = sustain_level;
        RELEASE: begin
          level_next = (release_rate == '0) ? '0 : floor_sub(level, release_rate, '0);
          if (level_next == '0) state_next = IDLE;
        end
        IDLE:    level_next = '0;
        default: begin
          state_next = IDLE;
          level_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      level  <= '0;
      active <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      active <= (state_next != IDLE);
      gate_q <= gate;
    end
  end

  // Output stage p1: scale by the level currently held in the register.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) sample_p1 <= '0;
    else                        sample_p1 <= scale(sample_in, level);
  end

  assign sample_out = sample_p1;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope walk-through plus randomized gate/rate
// traffic, all compared cycle by cycle against a behavioural envelope model.
module tb_adsr_envelope;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] sample_in = 8'd200;
  logic [7:0] attack_rate = 8'd0;
  logic [7:0] decay_rate = 8'd0;
  logic [7:0] sustain_level = 8'd0;
  logic [7:0] release_rate = 8'd0;
  logic [7:0] sample_out;
  logic [7:0] level;
  logic       active;

  int n_chk = 0;
  int n_err = 0;

  // Model: phase names as plain ints, arithmetic done on unbounded ints.
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
  int m_phase, m_level, m_cycles, m_out;
  bit m_gate_prev, m_active;

  adsr_envelope #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .gate(gate), .sample_in(sample_in),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .sample_out(sample_out), .level(level), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit tick_now, rise_now;
    if (reset) begin
      m_phase = P_IDLE; m_level = 0; m_cycles = 0; m_out = 0;
      m_gate_prev = 0; m_active = 0;
      return;
    end
    tick_now = (m_cycles % TD) == TD - 1;
    m_cycles++;
    rise_now = gate && !m_gate_prev;
    m_gate_prev = gate;
    m_out = (m_phase == P_IDLE) ? 0 : (int'(sample_in) * (m_level + 1)) / 256;
    if (rise_now) m_phase = P_ATK;
    else if (!gate && m_phase inside {P_ATK, P_DEC, P_SUS}) m_phase = P_REL;
    else if (tick_now) begin
      if (m_phase == P_ATK) begin
        m_level = (attack_rate == 0) ? 255 : imin(255, m_level + attack_rate);
        if (m_level == 255) m_phase = P_DEC;
      end else if (m_phase == P_DEC) begin
        m_level = (decay_rate == 0) ? int'(sustain_level)
                                    : imax(sustain_level, m_level - decay_rate);
        if (m_level == sustain_level) m_phase = P_SUS;
      end else if (m_phase == P_SUS) begin
        m_level = sustain_level;
      end else if (m_phase == P_REL) begin
        m_level = (release_rate == 0) ? 0 : imax(0, m_level - release_rate);
        if (m_level == 0) m_phase = P_IDLE;
      end
    end
    m_active = (m_phase != P_IDLE);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("level", level, m_level);
    chk("sample_out", sample_out, m_out);
    chk("active", active, m_active);
  endtask

  task automatic wait_change(input string tag, input int exp);
    int prev;
    bit seen;
    prev = level;
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      step();
      if (level != prev) seen = 1;
    end
    chk(tag, seen ? int'(level) : -1, exp);
  endtask

  initial begin
    // Reset and idle behaviour
    reset = 1'b1;
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_out", sample_out, 0);
    chk("idle_active", active, 0);

    // Attack
    attack_rate = 8'd100; decay_rate = 8'd50; sustain_level = 8'd120;
    release_rate = 8'd40; gate = 1'b1;
    wait_change("atk1", 100);
    step();
    chk("scale_100", sample_out, 78);
    wait_change("atk2", 200);
    wait_change("atk3", 255);
    sample_in = 8'd255;
    step();
    chk("scale_255", sample_out, 255);

    // Decay into sustain, then live sustain change
    wait_change("dec1", 205);
    wait_change("dec2", 155);
    wait_change("dec3", 120);
    sustain_level = 8'd90;
    wait_change("sus", 90);

    // Release
    gate = 1'b0;
    step();
    chk("rel_hold_level", level, 90);
    chk("rel_active", active, 1);
    wait_change("rel1", 50);
    wait_change("rel2", 10);
    wait_change("rel3", 0);
    chk("rel_idle_active", active, 0);
    step();
    chk("rel_idle_out", sample_out, 0);

    // Retrigger during attack keeps level
    gate = 1'b1;
    wait_change("rtg1", 100);
    wait_change("rtg2", 200);
    gate = 1'b0; step();
    gate = 1'b1; step();
    chk("rtg_keep", level, 200);
    attack_rate = 8'd0;
    wait_change("atk_instant", 255);

    // Reset mid-decay with gate held high
    wait_change("dec_pre_rst", 205);
    reset = 1'b1;
    step();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out", sample_out, 0);
    chk("mid_rst_active", active, 0);
    reset = 1'b0;
    step();
    chk("post_rst_active", active, 1);
    chk("post_rst_level", level, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        decay_rate    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        release_rate  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 39) == 0) sustain_level = 8'($urandom_range(0, 255));
      sample_in = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
